// File: rtl/tex_req_arb.sv
// tex_req_arb -- round-robin arbiter that shares one texture unit request port
// among NUM_REQS clients, plus the response demux back to the originator.
//
// Request side:  req_valid/req_ready per requester with mask, u/v coords, LOD,
//                stage and tag. The winner is registered into a one-entry output
//                stage (out_*), with the requester index appended in the LSBs
//                of out_tag.
// Response side: rsp_in_* from the texture unit; the low SEL_BITS of rsp_in_tag
//                select which rsp_valid/rsp_ready pair is used. Data and the
//                stripped tag are broadcast to every requester.
// Clock/reset:   clk, reset_n (asynchronous, active low).

`ifndef TEX_LOD_BITS
`define TEX_LOD_BITS 4
`endif
`ifndef TEX_STAGE_BITS
`define TEX_STAGE_BITS 2
`endif

module tex_req_arb #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_LANES  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int RSP_DATA_W = 32,
  localparam int SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int OTAG_W    = TAG_WIDTH + SEL_BITS
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic [NUM_REQS-1:0]                                req_valid,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                 req_mask,
  input  logic [NUM_REQS-1:0][1:0][NUM_LANES-1:0][31:0]      req_coords,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][`TEX_LOD_BITS-1:0] req_lod,
  input  logic [NUM_REQS-1:0][`TEX_STAGE_BITS-1:0]           req_stage,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]                 req_tag,
  output logic [NUM_REQS-1:0]                                req_ready,
  output logic                                               out_valid,
  output logic [NUM_LANES-1:0]                               out_mask,
  output logic [1:0][NUM_LANES-1:0][31:0]                    out_coords,
  output logic [NUM_LANES-1:0][`TEX_LOD_BITS-1:0]            out_lod,
  output logic [`TEX_STAGE_BITS-1:0]                         out_stage,
  output logic [OTAG_W-1:0]                                  out_tag,
  input  logic                                               out_ready,
  input  logic                                               rsp_in_valid,
  input  logic [NUM_LANES-1:0][RSP_DATA_W-1:0]               rsp_in_data,
  input  logic [OTAG_W-1:0]                                  rsp_in_tag,
  output logic                                               rsp_in_ready,
  output logic [NUM_REQS-1:0]                                rsp_valid,
  output logic [NUM_LANES-1:0][RSP_DATA_W-1:0]               rsp_data,
  output logic [TAG_WIDTH-1:0]                               rsp_tag,
  input  logic [NUM_REQS-1:0]                                rsp_ready
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e                               r_state, w_state_nxt;
  logic [SEL_BITS-1:0]                  r_ptr, w_ptr_nxt, w_win;
  logic                                 w_found, w_accept, w_load;
  logic [NUM_REQS-1:0]                  w_gnt;

  logic [NUM_LANES-1:0]                 r_mask, w_mask;
  logic [1:0][NUM_LANES-1:0][31:0]      r_coords, w_coords;
  logic [NUM_LANES-1:0][`TEX_LOD_BITS-1:0] r_lod, w_lod;
  logic [`TEX_STAGE_BITS-1:0]           r_stage, w_stage;
  logic [OTAG_W-1:0]                    r_tag;
  logic [TAG_WIDTH-1:0]                 w_tag;

  logic [SEL_BITS-1:0]                  w_idx;
  logic                                 w_idx_ok;

  assign w_accept = (r_state == S_EMPTY) || out_ready;

  // Circular scan from the pointer, done as two ascending passes:
  // first the indices at/above the pointer, then the ones below it.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = SEL_BITS'(i);
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!w_found && req_valid[i] && (i < int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = SEL_BITS'(i);
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < NUM_REQS; i++)
      w_gnt[i] = w_found && (int'(w_win) == i);
  end

  assign req_ready = w_accept ? w_gnt : '0;
  assign w_load    = w_accept && w_found;
  assign w_ptr_nxt = (int'(w_win) == NUM_REQS - 1) ? '0 : (w_win + SEL_BITS'(1));

  // One-hot payload mux driven by the grant vector.
  always_comb begin
    w_mask   = '0;
    w_coords = '0;
    w_lod    = '0;
    w_stage  = '0;
    w_tag    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_gnt[i]) begin
        w_mask   = req_mask[i];
        w_coords = req_coords[i];
        w_lod    = req_lod[i];
        w_stage  = req_stage[i];
        w_tag    = req_tag[i];
      end
    end
  end

  // Output stage: when accepting, the stage fills if anyone won, else empties.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)
      w_state_nxt = w_found ? S_FULL : S_EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_EMPTY;
      r_ptr    <= '0;
      r_mask   <= '0;
      r_coords <= '0;
      r_lod    <= '0;
      r_stage  <= '0;
      r_tag    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_ptr    <= w_ptr_nxt;
        r_mask   <= w_mask;
        r_coords <= w_coords;
        r_lod    <= w_lod;
        r_stage  <= w_stage;
        r_tag    <= {w_tag, w_win};
      end
    end
  end

  assign out_valid  = (r_state == S_FULL);
  assign out_mask   = r_mask;
  assign out_coords = r_coords;
  assign out_lod    = r_lod;
  assign out_stage  = r_stage;
  assign out_tag    = r_tag;

  // Response demux. An out-of-range index is swallowed (ready=1, no valid)
  // so a corrupt tag cannot stall the texture unit.
  assign w_idx    = rsp_in_tag[SEL_BITS-1:0];
  assign rsp_data = rsp_in_data;
  assign rsp_tag  = rsp_in_tag[OTAG_W-1:SEL_BITS];

  always_comb begin
    w_idx_ok     = 1'b0;
    rsp_valid    = '0;
    rsp_in_ready = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (int'(w_idx) == i) begin
        w_idx_ok     = 1'b1;
        rsp_valid[i] = rsp_in_valid;
        rsp_in_ready = rsp_ready[i];
      end
    end
  end

  a_rsp_idx_legal: assert property (@(posedge clk) disable iff (!reset_n)
    rsp_in_valid |-> w_idx_ok)
    else $error("tex_req_arb: response index out of range");

endmodule
